// File: rtl/fdc_nodrive_pkg.sv
// rtl/fdc_nodrive_pkg.sv - shared types, command table and status constants for the no-drive FDC
package fdc_nodrive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARAM  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } fdc_state_e;

  localparam logic [4:0] CMD_READ_TRACK    = 5'h02;
  localparam logic [4:0] CMD_SPECIFY       = 5'h03;
  localparam logic [4:0] CMD_SENSE_DRIVE   = 5'h04;
  localparam logic [4:0] CMD_WRITE_DATA    = 5'h05;
  localparam logic [4:0] CMD_READ_DATA     = 5'h06;
  localparam logic [4:0] CMD_RECALIBRATE   = 5'h07;
  localparam logic [4:0] CMD_SENSE_INT     = 5'h08;
  localparam logic [4:0] CMD_WRITE_DELETED = 5'h09;
  localparam logic [4:0] CMD_READ_ID       = 5'h0A;
  localparam logic [4:0] CMD_READ_DELETED  = 5'h0C;
  localparam logic [4:0] CMD_FORMAT        = 5'h0D;
  localparam logic [4:0] CMD_SEEK          = 5'h0F;
  localparam logic [4:0] CMD_SCAN_EQ       = 5'h11;
  localparam logic [4:0] CMD_SCAN_LE       = 5'h19;
  localparam logic [4:0] CMD_SCAN_HE       = 5'h1D;

  localparam logic [3:0] NPARAM_INVALID = 4'hF;

  localparam int MSR_RQM = 7;
  localparam int MSR_DIO = 6;
  localparam int MSR_CB  = 4;

  localparam logic [7:0] ST0_SEEK_END = 8'h78;
  localparam logic [7:0] ST0_ABNORMAL = 8'h48;
  localparam logic [7:0] ST0_INVALID  = 8'h80;

  localparam int STB_MSR_RD  = 0;
  localparam int STB_DATA_RD = 1;
  localparam int STB_DATA_WR = 2;
  localparam int STB_CTRL_WR = 3;

  // Number of parameter bytes following the command byte.
  function automatic logic [3:0] cmd_nparam(input logic [4:0] code);
    case (code)
      CMD_READ_TRACK, CMD_WRITE_DATA, CMD_READ_DATA, CMD_WRITE_DELETED,
      CMD_READ_DELETED, CMD_SCAN_EQ, CMD_SCAN_LE, CMD_SCAN_HE: cmd_nparam = 4'd8;
      CMD_FORMAT:                                               cmd_nparam = 4'd5;
      CMD_SPECIFY, CMD_SEEK:                                    cmd_nparam = 4'd2;
      CMD_SENSE_DRIVE, CMD_RECALIBRATE, CMD_READ_ID:            cmd_nparam = 4'd1;
      CMD_SENSE_INT:                                            cmd_nparam = 4'd0;
      default:                                                  cmd_nparam = NPARAM_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/fdc_nodrive_bus_strobe.sv
// rtl/fdc_nodrive_bus_strobe.sv - start/end pulses for each decoded Z80 access
module fdc_bus_strobe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dec,
  output logic [3:0] start,
  output logic [3:0] fin
);

  logic [3:0] dec_q, dec_d;

  always_comb dec_d = dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign start = dec & ~dec_q;
  assign fin   = ~dec & dec_q;

endmodule

// File: rtl/fdc_nodrive_controller.sv
// rtl/fdc_nodrive_controller.sv - uPD765 phase sequencer that reports "no drive" to +3DOS
module fdc_nodrive_controller
  import fdc_nodrive_pkg::*;
#(
  parameter int EXEC_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        motor_on
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] EXEC_LOAD = CW'(EXEC_CYCLES - 1);

  logic       io_sel;
  logic [3:0] dec, stb_start, stb_fin;

  assign io_sel           = ~iorq_n & ~a[1];
  assign dec[STB_MSR_RD]  = io_sel & (a[15:12] == 4'h2) & ~rd_n;
  assign dec[STB_DATA_RD] = io_sel & (a[15:12] == 4'h3) & ~rd_n;
  assign dec[STB_DATA_WR] = io_sel & (a[15:12] == 4'h3) & ~wr_n;
  assign dec[STB_CTRL_WR] = io_sel & (a[15:12] == 4'h1) & ~wr_n;

  fdc_bus_strobe u_strobe (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (dec),
    .start (stb_start),
    .fin   (stb_fin)
  );

  fdc_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    cmd_q, cmd_d;
  logic [3:0]    nparam_q, nparam_d, pcount_q, pcount_d, np;
  logic [7:0]    param_q [5];
  logic [7:0]    param_d [5];
  logic [7:0]    res_q [7];
  logic [7:0]    res_d [7];
  logic [2:0]    res_len_q, res_len_d, idx_q, idx_d;
  logic          int_pending_q, int_pending_d, motor_q, motor_d;
  logic [7:0]    st0_pend_q, st0_pend_d, pcn_q, pcn_d, msr;
  logic [2:0]    hu;
  logic          chrn_valid;

  assign np         = cmd_nparam(din[4:0]);
  assign hu         = param_q[0][2:0];
  assign chrn_valid = (nparam_q == 4'd8);
  assign motor_on   = motor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      nparam_q      <= '0;
      pcount_q      <= '0;
      param_q       <= '{default: 8'h00};
      res_q         <= '{default: 8'h00};
      res_len_q     <= '0;
      idx_q         <= '0;
      int_pending_q <= 1'b0;
      st0_pend_q    <= '0;
      pcn_q         <= '0;
      motor_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      nparam_q      <= nparam_d;
      pcount_q      <= pcount_d;
      param_q       <= param_d;
      res_q         <= res_d;
      res_len_q     <= res_len_d;
      idx_q         <= idx_d;
      int_pending_q <= int_pending_d;
      st0_pend_q    <= st0_pend_d;
      pcn_q         <= pcn_d;
      motor_q       <= motor_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    nparam_d      = nparam_q;
    pcount_d      = pcount_q;
    param_d       = param_q;
    res_d         = res_q;
    res_len_d     = res_len_q;
    idx_d         = idx_q;
    int_pending_d = int_pending_q;
    st0_pend_d    = st0_pend_q;
    pcn_d         = pcn_q;
    motor_d       = stb_start[STB_CTRL_WR] ? din[3] : motor_q;

    case (state_q)
      ST_IDLE: begin
        if (stb_start[STB_DATA_WR]) begin
          cmd_d    = din[4:0];
          nparam_d = np;
          pcount_d = '0;
          if (np == NPARAM_INVALID) begin
            res_d[0]  = ST0_INVALID;
            res_len_d = 3'd1;
            idx_d     = '0;
            state_d   = ST_RESULT;
          end else if (np == 4'd0) begin
            cnt_d   = EXEC_LOAD;
            state_d = ST_EXEC;
          end else begin
            state_d = ST_PARAM;
          end
        end
      end
      ST_PARAM: begin
        if (stb_start[STB_DATA_WR]) begin
          // Only bytes 1..5 (hd/us and C/H/R/N) are ever reported back.
          if (pcount_q < 4'd5) param_d[pcount_q[2:0]] = din;
          pcount_d = pcount_q + 4'd1;
          if (pcount_q + 4'd1 == nparam_q) begin
            cnt_d   = EXEC_LOAD;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          idx_d = '0;
          case (cmd_q)
            CMD_SPECIFY: state_d = ST_IDLE;
            CMD_RECALIBRATE, CMD_SEEK: begin
              int_pending_d = 1'b1;
              st0_pend_d    = ST0_SEEK_END | {5'b0, hu};
              state_d       = ST_IDLE;
            end
            CMD_SENSE_DRIVE: begin
              res_d[0]  = {5'b0, hu};
              res_len_d = 3'd1;
              state_d   = ST_RESULT;
            end
            CMD_SENSE_INT: begin
              if (int_pending_q) begin
                res_d[0]      = st0_pend_q;
                res_d[1]      = pcn_q;
                res_len_d     = 3'd2;
                int_pending_d = 1'b0;
              end else begin
                res_d[0]  = ST0_INVALID;
                res_len_d = 3'd1;
              end
              state_d = ST_RESULT;
            end
            default: begin
              res_d[0]  = ST0_ABNORMAL | {5'b0, hu};
              res_d[1]  = 8'h00;
              res_d[2]  = 8'h00;
              res_d[3]  = chrn_valid ? param_q[1] : 8'h00;
              res_d[4]  = chrn_valid ? param_q[2] : 8'h00;
              res_d[5]  = chrn_valid ? param_q[3] : 8'h00;
              res_d[6]  = chrn_valid ? param_q[4] : 8'h00;
              res_len_d = 3'd7;
              state_d   = ST_RESULT;
            end
          endcase
        end
      end
      ST_RESULT: begin
        if (stb_fin[STB_DATA_RD]) begin
          if (idx_q == res_len_q - 3'd1) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    msr = 8'h00;
    case (state_q)
      ST_IDLE:   msr[MSR_RQM] = 1'b1;
      ST_PARAM:  begin msr[MSR_RQM] = 1'b1; msr[MSR_CB] = 1'b1; end
      ST_EXEC:   msr[MSR_CB] = 1'b1;
      ST_RESULT: begin msr[MSR_RQM] = 1'b1; msr[MSR_DIO] = 1'b1; msr[MSR_CB] = 1'b1; end
      default:   msr = 8'h00;
    endcase
    oe   = dec[STB_MSR_RD] | dec[STB_DATA_RD];
    dout = 8'hFF;
    if (dec[STB_MSR_RD])                             dout = msr;
    else if (dec[STB_DATA_RD] && state_q == ST_RESULT) dout = res_q[idx_q];
  end

  logic unused_ok;
  assign unused_ok = ^{stb_start[STB_MSR_RD], stb_start[STB_DATA_RD], stb_fin[STB_MSR_RD],
                       stb_fin[STB_DATA_WR], stb_fin[STB_CTRL_WR], a[11:2], a[0]};

endmodule

// File: tb/tb_fdc_nodrive_controller.sv
// tb/tb_fdc_nodrive_controller.sv - scoreboard bench for the no-drive FDC sequencer
module tb_fdc_nodrive_controller;

  localparam int EXEC = 16;
  localparam int P_IDLE = 0, P_PARAM = 1, P_EXEC = 2, P_RESULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        oe, motor_on;

  always #5 clk = ~clk;

  fdc_nodrive_controller #(.EXEC_CYCLES(EXEC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .din      (din),
    .dout     (dout),
    .oe       (oe),
    .motor_on (motor_on)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  string       name_q[$];

  int          m_phase;
  logic [7:0]  m_cmd[$];
  logic [7:0]  m_res[$];
  bit          m_int;
  logic [7:0]  m_st0;
  bit          m_motor;

  logic        oe_prev = 1'b0;
  logic [7:0]  mon_e;
  string       mon_n;

  always @(negedge clk) begin
    if (oe && !oe_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: dout=%02h while no read was expected", dout);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (dout !== mon_e) begin
          errors++;
          $display("FAIL %s: dout=%02h expected %02h", mon_n, dout, mon_e);
        end
      end
    end
    oe_prev = oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_nparam(input logic [4:0] c);
    int eight[8] = '{2, 5, 6, 9, 12, 17, 25, 29};
    foreach (eight[i]) if (int'(c) == eight[i]) return 8;
    if (c == 5'd13) return 5;
    if (c == 5'd3 || c == 5'd15) return 2;
    if (c == 5'd4 || c == 5'd7 || c == 5'd10) return 1;
    if (c == 5'd8) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_int = 1'b0; m_st0 = 8'h00; m_motor = 1'b0;
    m_cmd.delete(); m_res.delete();
  endtask

  task automatic model_write(input logic [7:0] d);
    int n;
    if (m_phase == P_IDLE) begin
      m_cmd.delete(); m_cmd.push_back(d);
      n = ref_nparam(d[4:0]);
      if (n < 0) begin m_res.delete(); m_res.push_back(8'h80); m_phase = P_RESULT; end
      else if (n == 0) m_phase = P_EXEC;
      else m_phase = P_PARAM;
    end else if (m_phase == P_PARAM) begin
      m_cmd.push_back(d);
      if (m_cmd.size() == ref_nparam(m_cmd[0][4:0]) + 1) m_phase = P_EXEC;
    end
  endtask

  task automatic model_exec_done();
    logic [4:0] code;
    logic [7:0] hu;
    int n;
    code = m_cmd[0][4:0];
    n    = ref_nparam(code);
    hu   = (n > 0) ? {5'b0, m_cmd[1][2:0]} : 8'h00;
    m_res.delete();
    if (code == 5'd3) m_phase = P_IDLE;
    else if (code == 5'd7 || code == 5'd15) begin
      m_int = 1'b1; m_st0 = 8'h78 | hu; m_phase = P_IDLE;
    end else begin
      if (code == 5'd4) m_res.push_back(hu);
      else if (code == 5'd8) begin
        if (m_int) begin m_res.push_back(m_st0); m_res.push_back(8'h00); m_int = 1'b0; end
        else m_res.push_back(8'h80);
      end else begin
        m_res.push_back(8'h48 | hu); m_res.push_back(8'h00); m_res.push_back(8'h00);
        for (int k = 2; k <= 5; k++) m_res.push_back((n == 8) ? m_cmd[k] : 8'h00);
      end
      m_phase = P_RESULT;
    end
  endtask

  function automatic logic [7:0] model_msr();
    case (m_phase)
      P_IDLE:  return 8'h80;
      P_PARAM: return 8'h90;
      P_EXEC:  return 8'h10;
      default: return 8'hD0;
    endcase
  endfunction

  function automatic logic [7:0] model_data_rd();
    logic [7:0] r;
    if (m_phase != P_RESULT) return 8'hFF;
    r = m_res.pop_front();
    if (m_res.size() == 0) m_phase = P_IDLE;
    return r;
  endfunction

  function automatic logic [15:0] rand_addr(input logic [3:0] hi);
    logic [15:0] r;
    r = 16'($urandom);
    r[15:12] = hi;
    r[1] = 1'b0;
    return r;
  endfunction

  task automatic bus(input logic [15:0] addr, input bit is_rd, input logic [7:0] d);
    @(posedge clk); #1;
    a = addr; din = d; iorq_n = 1'b0; rd_n = !is_rd; wr_n = is_rd;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a = 16'($urandom); din = 8'($urandom);
    if ($urandom_range(0, 1) == 1) @(posedge clk);
  endtask

  task automatic msr_rd();
    exp_q.push_back(model_msr()); name_q.push_back("msr_read");
    bus(rand_addr(4'h2), 1'b1, 8'h00);
  endtask

  task automatic msr_rd_exp(input logic [7:0] e);
    exp_q.push_back(e); name_q.push_back("msr_read_fixed");
    bus(rand_addr(4'h2), 1'b1, 8'h00);
  endtask

  task automatic data_rd();
    exp_q.push_back(model_data_rd()); name_q.push_back("data_read");
    bus(rand_addr(4'h3), 1'b1, 8'h00);
  endtask

  task automatic data_rd_exp(input logic [7:0] e);
    void'(model_data_rd());
    exp_q.push_back(e); name_q.push_back("data_read_fixed");
    bus(rand_addr(4'h3), 1'b1, 8'h00);
  endtask

  task automatic data_wr(input logic [7:0] d);
    bus(rand_addr(4'h3), 1'b0, d);
    model_write(d);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    bus(rand_addr(4'h1), 1'b0, d);
    m_motor = d[3];
    check("motor_on", motor_on, m_motor);
  endtask

  task automatic wait_exec();
    repeat (EXEC + 2) @(posedge clk);
    model_exec_done();
  endtask

  // Last parameter write followed immediately by one long MSR read spanning execution.
  task automatic exec_timing(input logic [7:0] last);
    int n;
    @(posedge clk); #1;
    a = rand_addr(4'h3); din = last; iorq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
    @(posedge clk); #1;
    model_write(last);
    exp_q.push_back(8'h10); name_q.push_back("msr_exec_start");
    a = rand_addr(4'h2); wr_n = 1'b1; rd_n = 1'b0;
    n = 0;
    @(negedge clk);
    while (dout == 8'h10 && n < 4 * EXEC) begin n++; @(negedge clk); end
    check("exec_cycles", n, EXEC);
    model_exec_done();
    check("msr_after_exec", dout, model_msr());
    @(posedge clk); #1;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic run_cmd(input logic [7:0] b[$]);
    foreach (b[i]) begin
      data_wr(b[i]);
      if (m_phase == P_PARAM && $urandom_range(0, 3) == 0) msr_rd();
    end
    if (m_phase == P_EXEC) begin
      if ($urandom_range(0, 1) == 1) msr_rd();
      if ($urandom_range(0, 1) == 1) data_rd();
      else data_wr(8'($urandom));
      wait_exec();
    end
    msr_rd();
    while (m_phase == P_RESULT) begin
      if ($urandom_range(0, 3) == 0) msr_rd();
      if ($urandom_range(0, 5) == 0) data_wr(8'($urandom));
      data_rd();
    end
    msr_rd();
  endtask

  task automatic random_cmd();
    logic [4:0] vl[15] = '{5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                           5'h0A, 5'h0C, 5'h0D, 5'h0F, 5'h11, 5'h19, 5'h1D};
    logic [7:0] b[$];
    logic [4:0] c;
    int n;
    if ($urandom_range(0, 9) < 8) c = vl[$urandom_range(0, 14)];
    else c = 5'($urandom);
    b.push_back({3'($urandom), c});
    n = ref_nparam(c);
    for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    if ($urandom_range(0, 4) == 0) ctrl_wr(8'($urandom));
    run_cmd(b);
  endtask

  initial begin
    logic [7:0] rd_cmd[$];
    logic [7:0] rd_exp[$];
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 8'hFF);
    check("reset_oe", oe, 1'b0);
    check("reset_motor", motor_on, 1'b0);
    #2 rst_n = 1'b1;

    msr_rd_exp(8'h80);
    ctrl_wr(8'h08);
    ctrl_wr(8'h00);

    data_wr(8'h03);
    msr_rd_exp(8'h90);
    data_wr(8'hAF);
    exec_timing(8'h03);
    msr_rd_exp(8'h80);
    data_rd_exp(8'hFF);

    data_wr(8'h07);
    exec_timing(8'h01);
    data_wr(8'h08);
    wait_exec();
    msr_rd_exp(8'hD0);
    data_rd_exp(8'h79);
    data_rd_exp(8'h00);
    msr_rd_exp(8'h80);
    data_wr(8'h08);
    wait_exec();
    data_rd_exp(8'h80);
    msr_rd_exp(8'h80);

    rd_cmd = '{8'h46, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h01, 8'h2A, 8'hFF};
    rd_exp = '{8'h48, 8'h00, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02};
    foreach (rd_cmd[i]) data_wr(rd_cmd[i]);
    wait_exec();
    foreach (rd_exp[i]) data_rd_exp(rd_exp[i]);
    msr_rd_exp(8'h80);
    data_rd_exp(8'hFF);

    data_wr(8'h1F);
    msr_rd_exp(8'hD0);
    data_rd_exp(8'h80);
    msr_rd_exp(8'h80);

    bus(16'h3FFF, 1'b0, 8'h08);
    bus(16'h2FFF, 1'b1, 8'h00);
    bus(16'h1FFF, 1'b0, 8'h08);
    check("motor_a1_ignored", motor_on, 1'b0);
    msr_rd_exp(8'h80);

    repeat (40) random_cmd();

    ctrl_wr(8'h08);
    data_wr(8'h07);
    data_wr(8'h00);
    wait_exec();
    data_wr(8'h06);
    data_wr(8'h00);
    msr_rd_exp(8'h90);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midcmd_reset_motor", motor_on, 1'b0);
    check("midcmd_reset_dout", dout, 8'hFF);
    check("midcmd_reset_oe", oe, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    msr_rd_exp(8'h80);
    data_wr(8'h08);
    wait_exec();
    msr_rd_exp(8'hD0);
    data_rd_exp(8'h80);
    msr_rd_exp(8'h80);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
